// File: rtl/cpu_pkg.sv
// Shared decode types for the pipeline: control bundle, ALU/writeback selectors,
// RV32I opcode constants, and the controller / immediate generator functions.
package cpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [1:0] {ALU_SRC_REG, ALU_SRC_IMM, ALU_SRC_PC} alu_src_t;

    typedef enum logic [1:0] {WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC4} reg_write_src_t;

    // FMT_X marks an unsupported encoding: no immediate, no register reads.
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_t;

    typedef struct packed {
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
        logic           branch;
        logic           jump;
        alu_op_t        alu_op;
        alu_src_t       alu_src;
        reg_write_src_t reg_write_src;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        fmt_t  fmt;
        logic  illegal;
    } decode_t;

    function automatic alu_op_t alu_op_of(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t d;
        d     = '0;
        d.fmt = FMT_X;
        case (instr[6:0])
            OP_LUI: begin
                d.fmt = FMT_U; d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op = ALU_PASS_B; d.ctrl.alu_src = ALU_SRC_IMM;
            end
            OP_AUIPC: begin
                d.fmt = FMT_U; d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op = ALU_ADD; d.ctrl.alu_src = ALU_SRC_PC;
            end
            OP_JAL: begin
                d.fmt = FMT_J; d.ctrl.reg_write = 1'b1; d.ctrl.jump = 1'b1;
                d.ctrl.reg_write_src = WB_SRC_PC4;
            end
            OP_JALR: begin
                d.fmt = FMT_I; d.ctrl.reg_write = 1'b1; d.ctrl.jump = 1'b1;
                d.ctrl.alu_src = ALU_SRC_IMM; d.ctrl.reg_write_src = WB_SRC_PC4;
            end
            OP_BRANCH: begin
                d.fmt = FMT_B; d.ctrl.branch = 1'b1; d.ctrl.alu_op = ALU_SUB;
            end
            OP_LOAD: begin
                d.fmt = FMT_I; d.ctrl.reg_write = 1'b1; d.ctrl.mem_read = 1'b1;
                d.ctrl.alu_src = ALU_SRC_IMM; d.ctrl.reg_write_src = WB_SRC_MEM;
            end
            OP_STORE: begin
                d.fmt = FMT_S; d.ctrl.mem_write = 1'b1; d.ctrl.alu_src = ALU_SRC_IMM;
            end
            OP_IMM: begin
                // Only the shift-right form uses bit 30 as a selector; ADDI keeps it as immediate.
                d.fmt = FMT_I; d.ctrl.reg_write = 1'b1; d.ctrl.alu_src = ALU_SRC_IMM;
                d.ctrl.alu_op = alu_op_of(instr[14:12], instr[30] && (instr[14:12] == 3'b101));
            end
            OP_REG: begin
                d.fmt = FMT_R; d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op = alu_op_of(instr[14:12], instr[30]);
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input fmt_t fmt);
        case (fmt)
            FMT_I:   return {{20{instr[31]}}, instr[31:20]};
            FMT_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   return {instr[31:12], 12'b0};
            FMT_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input fmt_t fmt);
        return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    endfunction

    function automatic logic reads_rs2(input fmt_t fmt);
        return (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: x0 hard-wired to zero, two combinational read
// ports, one write port with optional same-cycle write-through.
module register_file #(
    parameter  int XLEN      = 32,
    parameter  int NUM_REGS  = 32,
    parameter  int WB_BYPASS = 1,
    localparam int REG_AW    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] rf_q [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_reg
                logic [XLEN-1:0] entry_reg;
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn)
                        entry_reg <= '0;
                    else if (we && waddr == REG_AW'(gi))
                        entry_reg <= wdata;
                end
                assign rf_q[gi] = entry_reg;
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_rport
            logic [REG_AW-1:0] addr;
            logic [XLEN-1:0]   data;
            assign addr = (gi == 0) ? raddr1 : raddr2;
            always_comb begin
                data = '0;
                if (addr != '0) begin
                    data = rf_q[addr];
                    if (WB_BYPASS != 0 && we && waddr == addr)
                        data = wdata;
                end
            end
        end
    endgenerate

    assign rdata1 = g_rport[0].data;
    assign rdata2 = g_rport[1].data;

endmodule

// File: rtl/decode_pipe_stage.sv
// Instruction decode stage: combinational decode + regfile read feeding a single
// ID/EX register, with load-use stall, flush, and held-operand refresh from WB.
module decode_pipe_stage
    import cpu_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NUM_REGS  = 32,
    parameter  int WB_BYPASS = 1,
    localparam int REG_AW    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_ready,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_reg_write_rd,
    input  logic [XLEN-1:0]   wb_reg_write_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc,
    output logic [REG_AW-1:0] id_rs1,
    output logic [REG_AW-1:0] id_rs2,
    output logic [REG_AW-1:0] id_rd,
    output logic [XLEN-1:0]   id_rd1,
    output logic [XLEN-1:0]   id_rd2,
    output logic [XLEN-1:0]   id_imm,
    output logic [XLEN-1:0]   id_branch_target,
    output ctrl_t             id_ctrl,
    output logic              id_illegal
);

    decode_t           dec;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic [XLEN-1:0]   rf_rd1;
    logic [XLEN-1:0]   rf_rd2;
    logic              load_use;
    logic              accept;

    always_comb begin
        dec     = decode_instr(if_instr);
        imm32   = gen_imm(if_instr, dec.fmt);
        imm_ext = XLEN'($signed(imm32));
        dec_rs1 = REG_AW'(if_instr[19:15]);
        dec_rs2 = REG_AW'(if_instr[24:20]);
        dec_rd  = REG_AW'(if_instr[11:7]);
    end

    register_file #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk    (clk),
        .rstn   (rstn),
        .we     (wb_reg_write),
        .waddr  (wb_reg_write_rd),
        .wdata  (wb_reg_write_data),
        .raddr1 (dec_rs1),
        .raddr2 (dec_rs2),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // A held load whose destination feeds the incoming instruction must leave
    // before that instruction can read its operands.
    always_comb begin
        load_use = id_valid && id_ctrl.mem_read && (id_rd != '0) && if_valid &&
                   ((reads_rs1(dec.fmt) && (id_rd == dec_rs1)) ||
                    (reads_rs2(dec.fmt) && (id_rd == dec_rs2)));
        if_ready = (!id_valid || ex_ready) && !load_use && !flush;
        accept   = if_valid && if_ready;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_valid         <= 1'b0;
            id_illegal       <= 1'b0;
            id_ctrl          <= '0;
            id_pc            <= '0;
            id_rs1           <= '0;
            id_rs2           <= '0;
            id_rd            <= '0;
            id_rd1           <= '0;
            id_rd2           <= '0;
            id_imm           <= '0;
            id_branch_target <= '0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            id_illegal <= 1'b0;
        end else if (accept) begin
            id_valid         <= 1'b1;
            id_illegal       <= dec.illegal;
            id_ctrl          <= dec.ctrl;
            id_pc            <= if_pc;
            id_rs1           <= dec_rs1;
            id_rs2           <= dec_rs2;
            id_rd            <= dec_rd;
            id_rd1           <= rf_rd1;
            id_rd2           <= rf_rd2;
            id_imm           <= imm_ext;
            id_branch_target <= if_pc + imm_ext;
        end else if (id_valid && ex_ready) begin
            // Transfer with nothing accepted: bubble.
            id_valid   <= 1'b0;
            id_illegal <= 1'b0;
        end else if (id_valid) begin
            // Stalled: keep captured operands coherent with writeback.
            if (wb_reg_write && wb_reg_write_rd != '0 && wb_reg_write_rd == id_rs1)
                id_rd1 <= wb_reg_write_data;
            if (wb_reg_write && wb_reg_write_rd != '0 && wb_reg_write_rd == id_rs2)
                id_rd2 <= wb_reg_write_data;
        end
    end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: stimulus pushes expected ID/EX transfers
// into a queue; a negedge monitor pops and compares every transfer to EX.
module tb_decode_pipe_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        wb_reg_write;
    logic [4:0]  wb_reg_write_rd;
    logic [31:0] wb_reg_write_data;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, id_branch_target;
    ctrl_t       id_ctrl;
    logic        id_illegal;

    always #5 clk = ~clk;

    decode_pipe_stage #(.XLEN(32), .NUM_REGS(32), .WB_BYPASS(1)) dut (
        .clk(clk), .rstn(rstn),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .wb_reg_write(wb_reg_write), .wb_reg_write_rd(wb_reg_write_rd),
        .wb_reg_write_data(wb_reg_write_data),
        .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_branch_target(id_branch_target),
        .id_ctrl(id_ctrl), .id_illegal(id_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, bt;
        logic [4:0]  flags;   // {reg_write, mem_read, mem_write, branch, jump}
        logic        illegal;
        logic        full;    // 0: only pc, flags, illegal are defined
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_txn(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [31:0] bt, input logic [4:0] flags,
                              input logic ill, input logic full);
        exp_t e;
        e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.rd1 = rd1; e.rd2 = rd2;
        e.imm = imm; e.bt = bt; e.flags = flags; e.illegal = ill; e.full = full;
        exp_q.push_back(e);
    endtask

    // Monitor: every EX transfer must match the oldest outstanding expectation.
    exp_t         mon_e;
    logic [180:0] mon_got, mon_want, mon_mask;
    always @(negedge clk) begin
        if (rstn && id_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got transfer pc=%h, expected none", id_pc);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_got  = {id_pc, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_branch_target,
                            id_ctrl.reg_write, id_ctrl.mem_read, id_ctrl.mem_write,
                            id_ctrl.branch, id_ctrl.jump, id_illegal};
                mon_want = {mon_e.pc, mon_e.rs1, mon_e.rs2, mon_e.rd, mon_e.rd1, mon_e.rd2,
                            mon_e.imm, mon_e.bt, mon_e.flags, mon_e.illegal};
                mon_mask = mon_e.full ? {181{1'b1}} : {32'hFFFF_FFFF, 143'b0, 6'h3F};
                n_cmp++;
                if ((mon_got & mon_mask) !== (mon_want & mon_mask)) begin
                    n_err++;
                    $display("FAIL txn pc=%h: got %h, expected %h", mon_e.pc,
                             mon_got & mon_mask, mon_want & mon_mask);
                end else begin
                    $display("txn pc=%h rd=%0d rd1=%h rd2=%h imm=%h tgt=%h ok",
                             id_pc, id_rd, id_rd1, id_rd2, id_imm, id_branch_target);
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rs2, input logic [4:0] rs1,
                                            input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [12:0] imm, input logic [4:0] rs2,
                                            input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction until accepted; returns just after the accepting edge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        logic rdy;
        logic ok;
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        ok       = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            rdy = if_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: got no accept for pc=%h, expected accept within 20 cycles", pc);
        end
        if_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_reg_write      = 1'b1;
        wb_reg_write_rd   = rd;
        wb_reg_write_data = data;
        step();
        wb_reg_write      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        wb_reg_write = 1'b0; wb_reg_write_rd = '0; wb_reg_write_data = '0;
        flush = 1'b0; ex_ready = 1'b1;

        // Reset state and first cycle after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        rstn = 1'b1;
        #1;
        check("post_rst_if_ready", 32'(if_ready), 32'd1);
        step();

        // ADDI x1,x0,5
        expect_txn(32'h100, 5'd0, 5'd5, 5'd1, 32'd0, 32'd0, 32'd5, 32'h105, 5'b10000, 1'b0, 1'b1);
        issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13), 32'h100);
        @(negedge clk);
        check("addi_id_valid", 32'(id_valid), 32'd1);
        check("addi_id_imm", id_imm, 32'd5);
        check("addi_id_rd", 32'(id_rd), 32'd1);
        check("addi_reg_write", 32'(id_ctrl.reg_write), 32'd1);
        step();

        // WB write-through on the same cycle as decode, and x0 write ignored
        wb_reg_write = 1'b1; wb_reg_write_rd = 5'd5; wb_reg_write_data = 32'h1234;
        expect_txn(32'h104, 5'd5, 5'd0, 5'd6, 32'h1234, 32'd0, 32'd0, 32'h104, 5'b10000, 1'b0, 1'b1);
        issue(enc_add(5'd0, 5'd5, 5'd6), 32'h104);
        wb_reg_write_rd = 5'd0; wb_reg_write_data = 32'hFFFF;
        expect_txn(32'h108, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 32'h108, 5'b10000, 1'b0, 1'b1);
        issue(enc_add(5'd0, 5'd0, 5'd7), 32'h108);
        wb_reg_write = 1'b0;
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);

        // Load-use: LW x2,0(x1) then ADD x3,x2,x2
        expect_txn(32'h200, 5'd1, 5'd0, 5'd2, 32'h11, 32'd0, 32'd0, 32'h200, 5'b11000, 1'b0, 1'b1);
        expect_txn(32'h204, 5'd2, 5'd2, 5'd3, 32'h22, 32'h22, 32'd0, 32'h204, 5'b10000, 1'b0, 1'b1);
        issue(enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'h03), 32'h200);
        if_valid = 1'b1; if_instr = enc_add(5'd2, 5'd2, 5'd3); if_pc = 32'h204;
        @(negedge clk);
        check("lu_if_ready_stall", 32'(if_ready), 32'd0);
        @(negedge clk);
        check("lu_bubble", 32'(id_valid), 32'd0);
        check("lu_if_ready_after", 32'(if_ready), 32'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        @(negedge clk);
        check("lu_add_valid", 32'(id_valid), 32'd1);
        step();

        // Stall with WB update of held operand: ADD x3,x1,x2, x1 <= 0xDEAD
        ex_ready = 1'b0;
        expect_txn(32'h300, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'h22, 32'd0, 32'h300, 5'b10000, 1'b0, 1'b1);
        issue(enc_add(5'd2, 5'd1, 5'd3), 32'h300);
        wb_reg_write = 1'b1; wb_reg_write_rd = 5'd1; wb_reg_write_data = 32'hDEAD;
        @(negedge clk);
        check("hold_rd1_pre", id_rd1, 32'h11);
        step();
        wb_reg_write = 1'b0;
        @(negedge clk);
        check("hold_rd1_updated", id_rd1, 32'hDEAD);
        check("hold_rd2_stable", id_rd2, 32'h22);
        check("hold_pc_stable", id_pc, 32'h300);
        check("hold_valid", 32'(id_valid), 32'd1);
        step();
        step();
        ex_ready = 1'b1;
        step();

        // Flush with a held instruction and a same-cycle IF instruction
        ex_ready = 1'b0;
        issue(enc_i(12'd1, 5'd0, 3'b000, 5'd8, 7'h13), 32'h400);
        if_valid = 1'b1; if_instr = enc_i(12'd2, 5'd0, 3'b000, 5'd9, 7'h13); if_pc = 32'h404;
        flush = 1'b1;
        @(negedge clk);
        check("flush_if_ready", 32'(if_ready), 32'd0);
        step();
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        check("flush_id_valid", 32'(id_valid), 32'd0);
        step();

        // BEQ x1,x2,+0x20 at 0xFFFFFFF0: target wraps to 0x10
        expect_txn(32'hFFFF_FFF0, 5'd1, 5'd2, 5'd0, 32'hDEAD, 32'h22, 32'h20, 32'h10,
                   5'b00010, 1'b0, 1'b1);
        issue(enc_beq(13'h020, 5'd2, 5'd1), 32'hFFFF_FFF0);
        @(negedge clk);
        check("beq_target", id_branch_target, 32'h10);
        step();

        // Unsupported opcode
        expect_txn(32'h600, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'b00000, 1'b1, 1'b0);
        issue(32'hFFFF_FFFF, 32'h600);
        @(negedge clk);
        check("illegal_flag", 32'(id_illegal), 32'd1);
        step();

        // Reset pulsed mid-stall: outputs clear at once, held instruction dropped
        ex_ready = 1'b0;
        issue(enc_i(12'd3, 5'd1, 3'b000, 5'd10, 7'h13), 32'h500);
        @(negedge clk);
        check("pre_rst_rd1", id_rd1, 32'hDEAD);
        rstn = 1'b0;
        #1;
        check("arst_id_valid", 32'(id_valid), 32'd0);
        check("arst_id_pc", id_pc, 32'd0);
        check("arst_id_rd1", id_rd1, 32'd0);
        check("arst_id_imm", id_imm, 32'd0);
        check("arst_id_target", id_branch_target, 32'd0);
        check("arst_id_rd", 32'(id_rd), 32'd0);
        check("arst_id_ctrl", 32'(id_ctrl), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1; ex_ready = 1'b1;
        #1;
        check("arst_if_ready", 32'(if_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("arst_no_transfer", 32'(id_valid), 32'd0);
        step();

        // Register file cleared by reset
        expect_txn(32'h700, 5'd1, 5'd2, 5'd11, 32'd0, 32'd0, 32'd0, 32'h700, 5'b10000, 1'b0, 1'b1);
        issue(enc_add(5'd2, 5'd1, 5'd11), 32'h700);
        repeat (3) step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
